// File: rtl/sample_streamer.sv
// sample_streamer: captures one frame on start and streams it out as bytes over valid/ready.
// Build option ZERO_RLE_EN: zero-byte runs are sent as 0x00 followed by a run length (1..255).
module sample_streamer #(
  parameter int unsigned FRAME_BYTES = 2560
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [8*FRAME_BYTES-1:0] frame_in,
  output logic                     busy,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     done
);

  localparam int unsigned FW = 8 * FRAME_BYTES;
  localparam int unsigned IW = 12;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
`ifdef ZERO_RLE_EN
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_ZMARK  = 3'd3;
  localparam logic [2:0] S_ZCOUNT = 3'd4;
`endif

  logic [2:0]    state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [FW-1:0] frame_q;
  logic [7:0]    data_n, pres_byte;
  logic          valid_n, last_n, busy_n, done_n;
  logic          load, pres, finish;
`ifdef ZERO_RLE_EN
  logic [7:0]    run_q, run_n;
  logic          run_end_q, run_end_n;
`endif

  function automatic logic [7:0] byte_of(input logic [FW-1:0] f, input logic [IW-1:0] i);
    return f[{i, 3'b000} +: 8];
  endfunction

  assign idx_inc = idx + IW'(1);

  // Frame capture; the copy is independent of frame_in once taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_q <= '0;
    else if (load) frame_q <= frame_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ZERO_RLE_EN
      run_q     <= 8'd0;
      run_end_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      m_data    <= data_n;
      m_valid   <= valid_n;
      m_last    <= last_n;
      busy      <= busy_n;
      done      <= done_n;
`ifdef ZERO_RLE_EN
      run_q     <= run_n;
      run_end_q <= run_end_n;
`endif
    end
  end

  // Next state: 'pres' loads byte idx_n onto the output, 'finish' closes the frame
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    data_n    = m_data;
    valid_n   = m_valid;
    last_n    = m_last;
    busy_n    = busy;
    done_n    = 1'b0;
    load      = 1'b0;
    pres      = 1'b0;
    finish    = 1'b0;
    pres_byte = 8'h00;
`ifdef ZERO_RLE_EN
    run_n     = run_q;
    run_end_n = run_end_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          load   = 1'b1;
          idx_n  = '0;
          busy_n = 1'b1;
          pres   = 1'b1;
        end
      end
      S_SEND: begin
        if (m_ready) begin
          if (idx == LAST_IDX) finish = 1'b1;
          else begin
            idx_n = idx_inc;
            pres  = 1'b1;
          end
        end
      end
`ifdef ZERO_RLE_EN
      S_SCAN: begin
        // Byte idx is known zero; count it and decide whether the run continues
        run_n = run_q + 8'd1;
        if (idx == LAST_IDX) begin
          run_end_n = 1'b1;
          state_n   = S_ZMARK;
        end else begin
          idx_n = idx_inc;
          if (run_q == 8'd254 || byte_of(frame_q, idx_inc) != 8'h00) state_n = S_ZMARK;
        end
        if (state_n == S_ZMARK) begin
          valid_n = 1'b1;
          data_n  = 8'h00;
          last_n  = 1'b0;
        end
      end
      S_ZMARK: begin
        if (m_ready) begin
          state_n = S_ZCOUNT;
          data_n  = run_q;
          last_n  = run_end_q;
        end
      end
      S_ZCOUNT: begin
        if (m_ready) begin
          if (run_end_q) finish = 1'b1;
          else pres = 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (finish) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      valid_n = 1'b0;
      last_n  = 1'b0;
      done_n  = 1'b1;
    end

    if (pres) begin
      pres_byte = load ? frame_in[7:0] : byte_of(frame_q, idx_n);
`ifdef ZERO_RLE_EN
      if (pres_byte == 8'h00) begin
        state_n   = S_SCAN;
        valid_n   = 1'b0;
        last_n    = 1'b0;
        run_n     = 8'd0;
        run_end_n = 1'b0;
      end else
`endif
      begin
        state_n = S_SEND;
        valid_n = 1'b1;
        data_n  = pres_byte;
        last_n  = (idx_n == LAST_IDX);
      end
    end
  end

endmodule
